// File: rtl/reg_dump_reader.sv
// ============================================================================
// Module   : reg_dump_reader
// Purpose  : Walks a register-file address range over one read port and
//            streams (address, data) beats with valid/ready, count and checksum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_dump_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] first_addr_i,
    input  logic [ADDR_W-1:0] last_addr_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W:0]   count_o,
    output logic [DATA_W-1:0] checksum_o
);

    localparam logic [ADDR_W-1:0] c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   c_CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [ADDR_W-1:0]   r_end_addr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [ADDR_W:0]     r_count;
    logic [DATA_W-1:0]   r_checksum;

    logic                w_start_ok;
    logic                w_handshake;
    logic                w_last_beat;

    assign w_start_ok  = (r_state == S_IDLE) && start_i;
    assign w_handshake = (r_state == S_SEND) && ready_i;
    // Compare before incrementing so a range ending at the top address never wraps.
    assign w_last_beat = (r_cur_addr == r_end_addr);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = (first_addr_i > last_addr_i) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (ready_i) begin
                    w_state_nxt = w_last_beat ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cur_addr <= '0;
            r_end_addr <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_count    <= '0;
            r_checksum <= '0;
        end else begin
            if (w_start_ok) begin
                r_cur_addr <= first_addr_i;
                r_end_addr <= last_addr_i;
                r_count    <= '0;
                r_checksum <= '0;
            end
            if (r_state == S_READ) begin
                r_addr <= r_cur_addr;
                r_data <= rd_data_i;
            end
            if (w_handshake) begin
                r_count    <= r_count + c_CNT_ONE;
                r_checksum <= r_checksum + r_data;
                if (!w_last_beat) begin
                    r_cur_addr <= r_cur_addr + c_ADDR_ONE;
                end
            end
        end
    end

    assign rd_addr_o  = r_cur_addr;
    assign valid_o    = (r_state == S_SEND);
    assign addr_o     = r_addr;
    assign data_o     = r_data;
    assign busy_o     = (r_state != S_IDLE);
    assign done_o     = (r_state == S_DONE);
    assign count_o    = r_count;
    assign checksum_o = r_checksum;

endmodule

`default_nettype wire

// File: tb/tb_reg_dump_reader.sv
// ============================================================================
// Module   : tb_reg_dump_reader
// Purpose  : Randomized self-checking bench for reg_dump_reader against a
//            queue-based dump model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_dump_reader;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic [ADDR_W-1:0] first_addr_i;
    logic [ADDR_W-1:0] last_addr_i;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [DATA_W-1:0] rd_data_i;
    logic              valid_o;
    logic              ready_i;
    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] data_o;
    logic              busy_o;
    logic              done_o;
    logic [ADDR_W:0]   count_o;
    logic [DATA_W-1:0] checksum_o;

    logic [DATA_W-1:0] regs [32];
    assign rd_data_i = regs[rd_addr_o];

    reg_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .first_addr_i (first_addr_i),
        .last_addr_i  (last_addr_i),
        .rd_addr_o    (rd_addr_o),
        .rd_data_i    (rd_data_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .addr_o       (addr_o),
        .data_o       (data_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .count_o      (count_o),
        .checksum_o   (checksum_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Dump model: the expected beat list is built once at start from the
    // register contents; timing follows READ-then-SEND per beat.
    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } beat_t;

    beat_t             m_q[$];
    int                m_vcnt  = -1;   // cycles until valid_o expected, -1 = none
    bit                m_done  = 1'b0;
    bit                m_busy  = 1'b0;
    bit                m_idle  = 1'b1;
    bit                m_live  = 1'b0;
    logic [ADDR_W:0]   m_count = '0;
    logic [DATA_W-1:0] m_sum   = '0;

    always @(negedge clk_i) begin
        if (m_live) begin
            chk("valid_o", 64'(valid_o), 64'(m_vcnt == 0));
            if (m_vcnt == 0 && m_q.size() > 0) begin
                chk("addr_o", 64'(addr_o), 64'(m_q[0].a));
                chk("data_o", 64'(data_o), 64'(m_q[0].d));
            end
            if (m_vcnt == 1 && m_q.size() > 0) begin
                chk("rd_addr_o", 64'(rd_addr_o), 64'(m_q[0].a));
            end
            chk("done_o", 64'(done_o), 64'(m_done));
            chk("busy_o", 64'(busy_o), 64'(m_busy));
            chk("count_o", 64'(count_o), 64'(m_count));
            chk("checksum_o", 64'(checksum_o), 64'(m_sum));
        end
        if (rst_i) begin
            m_q.delete();
            m_vcnt  = -1;
            m_done  = 1'b0;
            m_busy  = 1'b0;
            m_idle  = 1'b1;
            m_count = '0;
            m_sum   = '0;
            m_live  = 1'b1;
        end else if (m_idle && start_i) begin
            m_q.delete();
            m_count = '0;
            m_sum   = '0;
            m_idle  = 1'b0;
            m_busy  = 1'b1;
            for (int a = int'(first_addr_i); a <= int'(last_addr_i); a++) begin
                m_q.push_back('{a: ADDR_W'(a), d: regs[a]});
            end
            if (m_q.size() == 0) begin
                m_done = 1'b1;
                m_vcnt = -1;
            end else begin
                m_vcnt = 1;
            end
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
            m_idle = 1'b1;
        end else if (m_vcnt == 1) begin
            m_vcnt = 0;
        end else if (m_vcnt == 0 && ready_i) begin
            m_count = m_count + 1'b1;
            m_sum   = m_sum + m_q[0].d;
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
                m_vcnt = -1;
                m_done = 1'b1;
            end else begin
                m_vcnt = 1;
            end
        end
    end

    function automatic logic pick_ready(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return cyc[0];
            default: return ($urandom_range(0, 3) != 0);
        endcase
    endfunction

    // Mode 0: ready always high, 1: toggling, 2: random, 3: random plus stray starts.
    task automatic run(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l,
                       input int mode, output int cyc);
        @(posedge clk_i); #1;
        start_i      = 1'b1;
        first_addr_i = f;
        last_addr_i  = l;
        ready_i      = pick_ready(mode, 0);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        cyc     = 1;
        while (!done_o && cyc < 4000) begin
            ready_i = pick_ready(mode, cyc);
            if (mode == 3) begin
                start_i      = 1'($urandom_range(0, 1));
                first_addr_i = ADDR_W'($urandom);
                last_addr_i  = ADDR_W'($urandom);
            end
            @(posedge clk_i); #1;
            cyc++;
        end
        start_i = 1'b0;
        if (!done_o) chk("done_timeout", 64'(done_o), 64'd1);
        @(posedge clk_i); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic [ADDR_W-1:0] f;
        logic [ADDR_W-1:0] l;

        rst_i        = 1'b1;
        start_i      = 1'b0;
        ready_i      = 1'b0;
        first_addr_i = '0;
        last_addr_i  = '0;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        rst_i = 1'b0;

        // Full dump of i*0x11111111.
        for (int i = 0; i < 32; i++) regs[i] = 32'h11111111 * 32'(i);
        run(5'd0, 5'd31, 0, cyc);
        chk("full_done_latency", 64'(cyc - 1), 64'd64);
        chk("full_count", 64'(count_o), 64'd32);
        // 496 * 0x11111111 mod 2^32
        chk("full_checksum", 64'(checksum_o), 64'h111110F0);

        run(5'd5, 5'd5, 0, cyc);
        chk("single_count", 64'(count_o), 64'd1);
        chk("single_checksum", 64'(checksum_o), 64'h55555555);

        run(5'd28, 5'd31, 1, cyc);
        chk("top_count", 64'(count_o), 64'd4);
        chk("top_checksum", 64'(checksum_o), 64'hDDDDDDD6);

        run(5'd10, 5'd3, 0, cyc);
        chk("empty_done_cycle", 64'(cyc), 64'd1);
        chk("empty_count", 64'(count_o), 64'd0);
        chk("empty_checksum", 64'(checksum_o), 64'd0);

        for (int i = 0; i < 4; i++) regs[i] = 32'hFFFFFFFF;
        run(5'd0, 5'd3, 2, cyc);
        chk("wrap_count", 64'(count_o), 64'd4);
        chk("wrap_checksum", 64'(checksum_o), 64'hFFFFFFFC);

        run(5'd2, 5'd9, 3, cyc);
        chk("noisy_count", 64'(count_o), 64'd8);

        // Reset while a beat is held in SEND.
        @(posedge clk_i); #1;
        start_i      = 1'b1;
        first_addr_i = 5'd0;
        last_addr_i  = 5'd31;
        ready_i      = 1'b0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("pre_rst_valid", 64'(valid_o), 64'd1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("midrst_valid", 64'(valid_o), 64'd0);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_addr", 64'(addr_o), 64'd0);
        chk("midrst_data", 64'(data_o), 64'd0);
        chk("midrst_count", 64'(count_o), 64'd0);
        chk("midrst_checksum", 64'(checksum_o), 64'd0);
        repeat (4) begin
            chk("midrst_no_done", 64'(done_o), 64'd0);
            @(posedge clk_i); #1;
        end

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            f = ADDR_W'($urandom);
            l = (t % 5 == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(int'(f), 31));
            run(f, l, 2 + (t % 2), cyc);
        end

        repeat (3) @(posedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
